// File: rtl/dm_responder.sv
// ---------------------------------------------------------------------------
// dm_responder
//   Word-organised data memory behind a valid/ready request channel and a
//   valid/ready response channel, with a programmable number of wait states
//   between request acceptance and response. One transaction in flight.
//
// Parameters
//   DEPTH_LOG2 : log2 of memory depth in 32-bit words.
//   LATENCY    : wait cycles between accept and response (0..15).
//
// Ports
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   req_valid / req_ready   : request handshake
//   req_write               : 1 = store, 0 = load
//   req_addr                : byte address
//   req_wdata / req_be      : store data and byte enables
//   resp_valid / resp_ready : response handshake
//   resp_rdata              : load data (0 for stores and errors)
//   resp_err                : misaligned or out-of-range access
// ---------------------------------------------------------------------------
module dm_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;

    logic [31:0] mem_q [DEPTH];

    // Access being committed: straight from the request port when LATENCY = 0
    // (commit happens on the accept edge), otherwise from the captured copy.
    logic                  commit;
    logic                  acc_write;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic [3:0]            acc_be;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  acc_bad;
    logic                  mem_we;
    logic [31:0]           mem_wdata;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        commit       = 1'b0;
        acc_write    = write_q;
        acc_addr     = addr_q;
        acc_wdata    = wdata_q;
        acc_be       = be_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    write_d     = req_write;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    be_d        = req_be;
                    req_ready_d = 1'b0;
                    if (LATENCY == 0) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        commit       = 1'b1;
                        acc_write    = req_write;
                        acc_addr     = req_addr;
                        acc_wdata    = req_wdata;
                        acc_be       = req_be;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    commit       = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    rdata_d      = '0;
                    err_d        = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        word_idx = acc_addr[DEPTH_LOG2+1:2];
        acc_bad  = (acc_addr[1:0] != 2'b00) || (acc_addr[31:DEPTH_LOG2+2] != '0);

        mem_wdata = mem_q[word_idx];
        for (int b = 0; b < 4; b++) begin
            if (acc_be[b]) mem_wdata[8*b +: 8] = acc_wdata[8*b +: 8];
        end
        mem_we = commit && acc_write && !acc_bad;

        if (commit) begin
            err_d   = acc_bad;
            rdata_d = (!acc_write && !acc_bad) ? mem_q[word_idx] : '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // NOTE: the memory is deliberately cleared by reset, so it is built from
    // resettable flops rather than a RAM macro; reset wins over a pending store.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[word_idx] <= mem_wdata;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
